// File: rtl/fetch_ctrl_pkg.sv
// Shared constants and helpers for the instruction-fetch sequencer.
package fetch_ctrl_pkg;

  localparam int unsigned DEF_ADDR_WIDTH  = 32;
  localparam int unsigned DEF_INSTR_WIDTH = 32;
  localparam logic [31:0] DEF_RESET_PC    = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR       = 32'h0000_0000;
  localparam int unsigned PC_INC          = 4;

  // A MIPS instruction address must be word aligned.
  function automatic logic misaligned(input logic [1:0] lo);
    return |lo;
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory bus plus IF/ID handshake of the fetch sequencer.
interface fetch_ctrl_if
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int unsigned INSTR_WIDTH = DEF_INSTR_WIDTH
);
  logic [ADDR_WIDTH-1:0]  imem_addr_87;
  logic                   imem_en_87;
  logic [INSTR_WIDTH-1:0] imem_instr_87;
  logic                   stall_87;
  logic                   redirect_87;
  logic [ADDR_WIDTH-1:0]  redirect_pc_87;
  logic [INSTR_WIDTH-1:0] if_instr_87;
  logic [ADDR_WIDTH-1:0]  if_pc_87;
  logic                   if_valid_87;
  logic                   misalign_87;

  // Fetch sequencer side.
  modport master (
    output imem_addr_87, imem_en_87, if_instr_87, if_pc_87, if_valid_87, misalign_87,
    input  imem_instr_87, stall_87, redirect_87, redirect_pc_87
  );

  // Memory / pipeline side.
  modport slave (
    input  imem_addr_87, imem_en_87, if_instr_87, if_pc_87, if_valid_87, misalign_87,
    output imem_instr_87, stall_87, redirect_87, redirect_pc_87
  );
endinterface

// File: rtl/if_hold_buf.sv
// One-entry hold buffer that parks a fetched instruction while IF/ID stalls.
module if_hold_buf
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int unsigned INSTR_WIDTH = DEF_INSTR_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   load_i,
  input  logic                   clear_i,
  input  logic [INSTR_WIDTH-1:0] instr_i,
  input  logic [ADDR_WIDTH-1:0]  pc_i,
  output logic                   valid_o,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0]  pc_o
);
  logic                   valid_q;
  logic [INSTR_WIDTH-1:0] instr_q;
  logic [ADDR_WIDTH-1:0]  pc_q;

  // Clear wins over load so a redirect always empties the buffer.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      instr_q <= instr_i;
      pc_q    <= pc_i;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;
endmodule

// File: rtl/fetch_ctrl.sv
// PC sequencer driving a 1-cycle-latency instruction memory, with a
// valid/stall handshake to IF/ID and redirect squashing of the in-flight read.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int unsigned           INSTR_WIDTH = DEF_INSTR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = ADDR_WIDTH'(DEF_RESET_PC)
) (
  input  logic        clk_87,
  input  logic        rst_n_87,
  fetch_ctrl_if.master bus
);
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic                   inflight_q, inflight_d;
  logic [ADDR_WIDTH-1:0]  inflight_pc_q;
  logic                   en_q;
  logic                   misalign_q, misalign_d;

  logic                   hold_valid;
  logic [INSTR_WIDTH-1:0] hold_instr;
  logic [ADDR_WIDTH-1:0]  hold_pc;
  logic                   hold_next;
  logic                   accept;

  logic                   out_valid;
  logic [INSTR_WIDTH-1:0] out_instr;
  logic [ADDR_WIDTH-1:0]  out_pc;

  if_hold_buf #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INSTR_WIDTH(INSTR_WIDTH)
  ) u_hold (
    .clk_i  (clk_87),
    .rst_n_i(rst_n_87),
    .load_i (!hold_valid && hold_next),
    .clear_i(!hold_next),
    .instr_i(bus.imem_instr_87),
    .pc_i   (inflight_pc_q),
    .valid_o(hold_valid),
    .instr_o(hold_instr),
    .pc_o   (hold_pc)
  );

  // Output mux: held instruction first, then the memory read that just returned.
  always_comb begin
    out_valid = 1'b0;
    out_instr = INSTR_WIDTH'(NOP_INSTR);
    out_pc    = '0;
    if (hold_valid) begin
      out_valid = 1'b1;
      out_instr = hold_instr;
      out_pc    = hold_pc;
    end else if (inflight_q) begin
      out_valid = 1'b1;
      out_instr = bus.imem_instr_87;
      out_pc    = inflight_pc_q;
    end
  end

  assign accept = out_valid && !bus.stall_87;

  // Next-state: redirect beats stall; a stalled read is discarded and re-issued.
  // No read is issued until en_q is up, so the PC waits one cycle after reset.
  always_comb begin
    if (bus.redirect_87)  hold_next = 1'b0;
    else if (hold_valid)  hold_next = !accept;
    else                  hold_next = inflight_q && bus.stall_87;

    pc_d = pc_q;
    if (bus.redirect_87)
      pc_d = {bus.redirect_pc_87[ADDR_WIDTH-1:2], 2'b00};
    else if (en_q && !hold_next)
      pc_d = pc_q + ADDR_WIDTH'(PC_INC);

    inflight_d = en_q && !bus.redirect_87 && !hold_next;
    misalign_d = bus.redirect_87 && misaligned(bus.redirect_pc_87[1:0]);
  end

  // PC, in-flight tracking, memory enable and misalign pulse registers.
  always_ff @(posedge clk_87 or negedge rst_n_87) begin
    if (!rst_n_87) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      en_q          <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= pc_q;
      en_q          <= 1'b1;
      misalign_q    <= misalign_d;
    end
  end

  assign bus.imem_addr_87 = pc_q;
  assign bus.imem_en_87   = en_q;
  assign bus.if_valid_87  = out_valid;
  assign bus.if_instr_87  = out_instr;
  assign bus.if_pc_87     = out_pc;
  assign bus.misalign_87  = misalign_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized bench for fetch_ctrl against a transaction-level model of the
// presented instruction stream.
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  fetch_ctrl_if #(.ADDR_WIDTH(32), .INSTR_WIDTH(32)) bus ();

  fetch_ctrl #(.ADDR_WIDTH(32), .INSTR_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk_87  (clk),
    .rst_n_87(rst_n),
    .bus     (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0001;
  endfunction

  // Synchronous-read instruction memory, one cycle of latency.
  initial bus.imem_instr_87 = 32'h0;
  always @(posedge clk)
    if (bus.imem_en_87) bus.imem_instr_87 <= mem_word(bus.imem_addr_87);

  // Model: what IF/ID is currently shown, plus the pending target and how
  // many more edges pass before that target shows up.
  logic        m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_tgt;
  int          m_cnt;
  logic        m_en;
  logic        m_mis;

  task automatic model_reset();
    m_valid = 1'b0;
    m_pc    = 32'h0;
    m_tgt   = 32'h0;
    m_cnt   = 2;
    m_en    = 1'b0;
    m_mis   = 1'b0;
  endtask

  task automatic model_edge(input logic s, input logic r, input logic [31:0] rp);
    if (r) begin
      m_valid = 1'b0;
      m_tgt   = rp & 32'hFFFF_FFFC;
      m_cnt   = 1;
    end else if (m_valid) begin
      if (!s) m_pc = m_pc + 32'd4;
    end else begin
      m_cnt = m_cnt - 1;
      if (m_cnt <= 0) begin
        m_valid = 1'b1;
        m_pc    = m_tgt;
      end
    end
    m_mis = r && (rp[1:0] != 2'b00);
    m_en  = 1'b1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("valid",    32'(bus.if_valid_87), 32'(m_valid));
    chk("if_pc",    bus.if_pc_87,    m_valid ? m_pc : 32'h0);
    chk("if_instr", bus.if_instr_87, m_valid ? mem_word(m_pc) : NOP_INSTR);
    chk("imem_addr", bus.imem_addr_87, m_valid ? m_pc + 32'd4 : m_tgt);
    chk("imem_en",  32'(bus.imem_en_87),  32'(m_en));
    chk("misalign", 32'(bus.misalign_87), 32'(m_mis));
  endtask

  task automatic step(input logic s, input logic r, input logic [31:0] rp);
    bus.stall_87       = s;
    bus.redirect_87    = r;
    bus.redirect_pc_87 = rp;
    @(posedge clk);
    model_edge(s, r, rp);
    @(negedge clk);
    bus.redirect_87 = 1'b0;
    check_all();
  endtask

  task automatic run(input int n, input logic s);
    for (int i = 0; i < n; i++) step(s, 1'b0, 32'h0);
  endtask

  logic [31:0] rnd;
  logic [31:0] rpc;

  initial begin
    n_checks           = 0;
    n_fail             = 0;
    rst_n              = 1'b0;
    bus.stall_87       = 1'b0;
    bus.redirect_87    = 1'b0;
    bus.redirect_pc_87 = 32'h0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // Startup and sequential fetch, then a 3-cycle stall at pc 8.
    run(4, 1'b0);
    run(3, 1'b1);
    run(3, 1'b0);
    // Redirect to 0x40 from a flowing stream.
    step(1'b0, 1'b1, 32'h40);
    run(3, 1'b0);
    // Redirect to 0x80 with the hold buffer full and stall held.
    run(3, 1'b1);
    step(1'b1, 1'b1, 32'h80);
    run(4, 1'b1);
    run(2, 1'b0);
    // Misaligned target, and wrap past the top of the address space.
    step(1'b0, 1'b1, 32'h42);
    run(3, 1'b0);
    step(1'b0, 1'b1, 32'hFFFF_FFFC);
    run(3, 1'b0);
    step(1'b1, 1'b1, 32'hFFFF_FFF8);
    run(2, 1'b1);
    run(3, 1'b0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      rnd = $urandom();
      case (rnd[2:0])
        3'd0:    rpc = 32'hFFFF_FFFC;
        3'd1:    rpc = {rnd[31:14], 12'h0, rnd[13:12] | 2'b01};
        default: rpc = {20'h0, rnd[15:4], 2'b00} ^ {30'h0, rnd[17:16] & {2{rnd[3]}}};
      endcase
      step(($urandom() % 4) == 0, ($urandom() % 9) == 0, rpc);
    end

    // Asynchronous reset in the middle of a stall.
    run(2, 1'b0);
    run(3, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(bus.if_valid_87), 32'h0);
    chk("rst_instr", bus.if_instr_87, NOP_INSTR);
    chk("rst_pc",    bus.if_pc_87, 32'h0);
    chk("rst_addr",  bus.imem_addr_87, 32'h0);
    chk("rst_en",    32'(bus.imem_en_87), 32'h0);
    chk("rst_mis",   32'(bus.misalign_87), 32'h0);
    model_reset();
    @(negedge clk);
    bus.stall_87 = 1'b0;
    check_all();
    rst_n = 1'b1;
    run(4, 1'b0);
    run(2, 1'b1);
    step(1'b0, 1'b1, 32'h0000_0123);
    run(4, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer for the MIPS pipeline.
- Owns the PC and drives the instruction memory, whose synchronous read has 1-cycle latency: address issued in cycle N, data valid in N+1.
- Presents a valid/stall handshake to the IF/ID register and absorbs back-pressure with a 1-entry hold buffer.
- Handles branch/jump redirects by squashing the in-flight read.

Parameters:
- ADDR_WIDTH, `ADDR_WIDTH (32): PC/address width.
- INSTR_WIDTH, `INSTR_WIDTH (32): instruction width.
- RESET_PC, 0: first fetch address after reset.

Ports:
- clk_87  in  1  clock; all state updates on rising edge.
- rst_n_87  in  1  asynchronous active-low reset.
- imem_addr_87  out  ADDR_WIDTH  byte address to instruction memory; equals pc_q.
- imem_en_87  out  1  instruction memory output enable.
- imem_instr_87  in  INSTR_WIDTH  read data for the address issued the previous cycle.
- stall_87  in  1  IF/ID not accepting (hazard unit).
- redirect_87  in  1  branch/jump taken; single-cycle pulse.
- redirect_pc_87  in  ADDR_WIDTH  redirect target.
- if_instr_87  out  INSTR_WIDTH  fetched instruction; `NOP_INSTR when if_valid_87=0.
- if_pc_87  out  ADDR_WIDTH  address of if_instr_87.
- if_valid_87  out  1  if_instr_87/if_pc_87 valid.
- misalign_87  out  1  registered 1-cycle pulse: redirect target had addr[1:0]!=0.

Behaviour:
- Registers and reset values (all asynchronous, on rst_n_87=0):
  - pc_q=RESET_PC
  - inflight_q=0, inflight_pc_q=0
  - hold_q=0, hold_instr_q=0, hold_pc_q=0
  - en_q=0, misalign_q=0
- Reset output values: imem_addr_87=RESET_PC, imem_en_87=0, if_valid_87=0, if_instr_87=`NOP_INSTR, if_pc_87=0, misalign_87=0.
- imem_en_87=en_q. en_q goes to 1 on the first edge after reset release and stays 1.
- Output mux (combinational):
  - hold_q=1: output hold_instr_q/hold_pc_q, valid=1.
  - else inflight_q=1: output imem_instr_87/inflight_pc_q, valid=1.
  - else: valid=0, NOP, pc=0.
- accept = if_valid_87 & !stall_87.
- hold_next:
  - redirect_87: 0.
  - else hold_q: !accept.
  - else: inflight_q & stall_87. This captures imem_instr_87/inflight_pc_q into the hold registers.
- inflight_q <= !redirect_87 & !hold_next. inflight_pc_q <= pc_q.
- pc_q update:
  - redirect_87: {redirect_pc_87[ADDR_WIDTH-1:2],2'b00}.
  - else hold_next: hold pc_q. The current read is discarded and re-issued later.
  - else: pc_q+4, wrapping modulo 2^ADDR_WIDTH (0xFFFFFFFC -> 0).
- Priority: reset > redirect > stall.
  - Redirect overrides stall and clears the hold buffer.
  - Redirect in cycle R: R+1 outputs a bubble while target is issued; target instruction valid in R+2 (2-cycle penalty).
- Latency: first valid instruction (RESET_PC) on the 2nd rising edge after reset release. Steady-state throughput is 1 instruction/cycle.
- Stall entry and release:
  - Stall with a valid mem-sourced output: no instruction lost, none duplicated.
  - Release: held instruction accepted, next sequential instruction valid the following cycle, no bubble.
- Stall while if_valid_87=0: fetch continues; the next returning instruction is captured if stall persists.
- misalign_q <= redirect_87 & |redirect_pc_87[1:0].
- Reset asserted mid-stall or mid-redirect: all state cleared immediately; no output pulse survives.

Decomposition:
- Add to mips_defs.vh: `RESET_PC, `NOP_INSTR (32'h0000_0000), `PC_INC (4).
- Sub-module if_hold_buf: 1-entry hold register with load/clear/valid, instr+pc payload, async active-low reset.
- fetch_ctrl instantiates if_hold_buf and contains the pc/inflight logic.

Test Plan:
- Reset release, no stall:
  - imem_addr_87 = 0,4,8,12 on consecutive cycles.
  - if_valid_87 first high at edge 2 with if_pc_87=0, then 4,8 each cycle.
  - if_instr_87 matches the memory image.
- stall_87 high 3 cycles while if_pc_87=8:
  - if_pc_87 stays 8 with stable instruction.
  - imem_addr_87 holds 12.
  - After release, 12 then 16 appear on consecutive cycles; no gap, no repeat.
- redirect_87 with redirect_pc_87=0x40 while if_pc_87=8:
  - Next cycle if_valid_87=0 and imem_addr_87=0x40.
  - Following cycle if_pc_87=0x40, then 0x44.
- redirect_87 with redirect_pc_87=0x80 during an active stall with the hold buffer full:
  - Hold buffer cleared, bubble, then 0x80 valid.
  - stall_87 still high: 0x80 remains presented.
- redirect_pc_87=0x42:
  - misalign_87 pulses 1 cycle.
  - Fetch resumes at 0x40.
- Redirect to 0xFFFFFFFC: if_pc_87 sequence 0xFFFFFFFC, 0x0. rst_n_87 low mid-stall: outputs return to reset values asynchronously.
